// File: rtl/noc_packet_interface.sv
// noc_packet_interface
//
// Network interface between a processor node's memory-mapped I/O strobes and
// its Hoplite router port.
//
// Transmit side: the processor writes a destination x, a destination y and a
// message into staging registers. A packet_complete strobe copies them into
// the output register, which is offered to the router with a valid/ready
// handshake. A commit made while the output register is still occupied is
// dropped, and the sticky tx_overflow flag is set.
//
// Receive side: once the processor strobes rx_enable, ejected packets are
// pushed into a small show-ahead FIFO. The processor polls the FIFO head and
// pops it with rx_read.
//
// Ports:
//   clk, reset                      clock; asynchronous active-high reset
//   x_coord_in / x_coord_in_valid   destination x staging write
//   y_coord_in / y_coord_in_valid   destination y staging write
//   message_in / message_in_valid   payload staging write
//   packet_complete                 commit the staging registers as a packet
//   message_out_ready               TX slot free (registered)
//   tx_overflow                     sticky; a commit was rejected
//   router_out_packet/valid/ready   injection handshake to the router
//   router_in_packet/valid/ready    ejection handshake from the router
//   rx_enable                       sticky receive-enable strobe
//   rx_message                      FIFO head payload (show-ahead)
//   rx_available                    FIFO not empty
//   rx_valid                        head is addressed to this node
//   rx_read                         pop the FIFO head
module noc_packet_interface #(
  parameter int COORD_BITS    = 1,
  parameter int MESSAGE_BITS  = 32,
  parameter int X_COORD       = 0,
  parameter int Y_COORD       = 0,
  parameter int RX_FIFO_DEPTH = 4,
  parameter int PACKET_BITS   = 2*COORD_BITS+MESSAGE_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COORD_BITS-1:0]   x_coord_in,
  input  logic                    x_coord_in_valid,
  input  logic [COORD_BITS-1:0]   y_coord_in,
  input  logic                    y_coord_in_valid,
  input  logic [MESSAGE_BITS-1:0] message_in,
  input  logic                    message_in_valid,
  input  logic                    packet_complete,
  output logic                    message_out_ready,
  output logic                    tx_overflow,
  output logic [PACKET_BITS-1:0]  router_out_packet,
  output logic                    router_out_valid,
  input  logic                    router_out_ready,
  input  logic [PACKET_BITS-1:0]  router_in_packet,
  input  logic                    router_in_valid,
  output logic                    router_in_ready,
  input  logic                    rx_enable,
  output logic [MESSAGE_BITS-1:0] rx_message,
  output logic                    rx_available,
  output logic                    rx_valid,
  input  logic                    rx_read
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);

  // ---------------------------------------------------------------- TX side
  logic [COORD_BITS-1:0]   x_stage_reg;
  logic [COORD_BITS-1:0]   y_stage_reg;
  logic [MESSAGE_BITS-1:0] msg_stage_reg;
  logic [PACKET_BITS-1:0]  out_packet_reg;
  logic                    out_valid_reg;
  logic                    out_valid_next;
  logic                    out_ready_reg;
  logic                    overflow_reg;
  logic                    commit_ok;

  // A commit is taken when the slot is empty or is being emptied this cycle.
  always_comb begin
    commit_ok      = packet_complete & (~out_valid_reg | router_out_ready);
    out_valid_next = commit_ok | (out_valid_reg & ~router_out_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_stage_reg    <= '0;
      y_stage_reg    <= '0;
      msg_stage_reg  <= '0;
      out_packet_reg <= '0;
      out_valid_reg  <= 1'b0;
      out_ready_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      if (x_coord_in_valid) x_stage_reg   <= x_coord_in;
      if (y_coord_in_valid) y_stage_reg   <= y_coord_in;
      if (message_in_valid) msg_stage_reg <= message_in;
      // The commit samples the staging registers before this edge's writes.
      if (commit_ok) out_packet_reg <= {x_stage_reg, y_stage_reg, msg_stage_reg};
      if (packet_complete && !commit_ok) overflow_reg <= 1'b1;
      out_valid_reg <= out_valid_next;
      out_ready_reg <= ~out_valid_next;
    end
  end

  assign router_out_packet = out_packet_reg;
  assign router_out_valid  = out_valid_reg;
  assign message_out_ready = out_ready_reg;
  assign tx_overflow       = overflow_reg;

  // ---------------------------------------------------------------- RX side
  logic [PACKET_BITS-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [AW:0]            wr_ptr_reg;
  logic [AW:0]            rd_ptr_reg;
  logic [AW:0]            wr_ptr_next;
  logic [AW:0]            rd_ptr_next;
  logic                   rx_en_reg;
  logic                   rx_en_next;
  logic                   in_ready_reg;
  logic                   fifo_empty;
  logic                   fifo_full_next;
  logic                   push;
  logic                   pop;
  logic [PACKET_BITS-1:0] head;
  logic [COORD_BITS-1:0]  head_x;
  logic [COORD_BITS-1:0]  head_y;

  always_comb begin
    fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
    push        = router_in_valid & in_ready_reg;
    pop         = rx_read & ~fifo_empty;
    wr_ptr_next = wr_ptr_reg + (AW+1)'(push);
    rd_ptr_next = rd_ptr_reg + (AW+1)'(pop);
    rx_en_next  = rx_en_reg | rx_enable;
    // Pointers carry one extra wrap bit: equal index with differing wrap
    // bits means every slot is occupied.
    fifo_full_next = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                     (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rx_en_reg    <= 1'b0;
      in_ready_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      rx_en_reg    <= rx_en_next;
      // Ready reflects the state after this edge, so it drops the cycle
      // after the filling push and returns the cycle after a pop.
      in_ready_reg <= rx_en_next & ~fifo_full_next;
    end
  end

  // One register per FIFO slot; the array is small enough that a
  // combinational head read keeps the FIFO show-ahead.
  for (genvar gi = 0; gi < RX_FIFO_DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        fifo_mem[gi] <= '0;
      end else if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
        fifo_mem[gi] <= router_in_packet;
      end
    end
  end

  always_comb begin
    head   = fifo_mem[rd_ptr_reg[AW-1:0]];
    head_x = head[PACKET_BITS-1 -: COORD_BITS];
    head_y = head[MESSAGE_BITS +: COORD_BITS];
  end

  assign router_in_ready = in_ready_reg;
  assign rx_available    = ~fifo_empty;
  assign rx_message      = head[MESSAGE_BITS-1:0];
  assign rx_valid        = ~fifo_empty &
                           (head_x == COORD_BITS'(X_COORD)) &
                           (head_y == COORD_BITS'(Y_COORD));

endmodule

// File: tb/tb_noc_packet_interface.sv
// Self-checking bench for noc_packet_interface (node at x=1, y=1, depth 4).
module tb_noc_packet_interface;

  localparam int CB = 1;
  localparam int MB = 32;
  localparam int PB = 2*CB+MB;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CB-1:0] x_coord_in = '0;
  logic          x_coord_in_valid = 1'b0;
  logic [CB-1:0] y_coord_in = '0;
  logic          y_coord_in_valid = 1'b0;
  logic [MB-1:0] message_in = '0;
  logic          message_in_valid = 1'b0;
  logic          packet_complete = 1'b0;
  logic          message_out_ready;
  logic          tx_overflow;
  logic [PB-1:0] router_out_packet;
  logic          router_out_valid;
  logic          router_out_ready = 1'b0;
  logic [PB-1:0] router_in_packet = '0;
  logic          router_in_valid = 1'b0;
  logic          router_in_ready;
  logic          rx_enable = 1'b0;
  logic [MB-1:0] rx_message;
  logic          rx_available;
  logic          rx_valid;
  logic          rx_read = 1'b0;

  noc_packet_interface #(
    .COORD_BITS(CB), .MESSAGE_BITS(MB), .X_COORD(1), .Y_COORD(1),
    .RX_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .x_coord_in(x_coord_in), .x_coord_in_valid(x_coord_in_valid),
    .y_coord_in(y_coord_in), .y_coord_in_valid(y_coord_in_valid),
    .message_in(message_in), .message_in_valid(message_in_valid),
    .packet_complete(packet_complete),
    .message_out_ready(message_out_ready), .tx_overflow(tx_overflow),
    .router_out_packet(router_out_packet), .router_out_valid(router_out_valid),
    .router_out_ready(router_out_ready),
    .router_in_packet(router_in_packet), .router_in_valid(router_in_valid),
    .router_in_ready(router_in_ready),
    .rx_enable(rx_enable), .rx_message(rx_message),
    .rx_available(rx_available), .rx_valid(rx_valid), .rx_read(rx_read)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PB-1:0] pk(input logic x, input logic y, input logic [31:0] m);
    return {x, y, m};
  endfunction

  typedef struct {
    logic        x;
    logic        xv;
    logic        y;
    logic        yv;
    logic [31:0] msg;
    logic        mv;
    logic        pc;
    logic        ordy;
    logic        e_valid;
    logic [PB-1:0] e_pkt;
    logic        e_mor;
    logic        e_ovf;
  } vec_t;

  function automatic vec_t mk(input logic x, input logic xv, input logic y, input logic yv,
                              input logic [31:0] msg, input logic mv, input logic pc,
                              input logic ordy, input logic ev, input logic [PB-1:0] ep,
                              input logic emor, input logic eovf);
    vec_t v;
    v.x = x; v.xv = xv; v.y = y; v.yv = yv; v.msg = msg; v.mv = mv; v.pc = pc;
    v.ordy = ordy; v.e_valid = ev; v.e_pkt = ep; v.e_mor = emor; v.e_ovf = eovf;
    return v;
  endfunction

  vec_t vecs[19];
  logic [PB-1:0] rxp[5];

  // Reference model state for the random phase
  logic          m_pend;
  logic [PB-1:0] m_pkt;
  logic          m_xs, m_ys;
  logic [31:0]   m_ms;
  logic          m_ovf;
  logic          m_en;
  logic [PB-1:0] m_q[$];

  initial begin
    // ---------------- reset state
    #1 reset = 1'b1;
    tick();
    tick();
    check("rst_mor", 64'(message_out_ready), 64'd0);
    check("rst_rin_ready", 64'(router_in_ready), 64'd0);
    check("rst_valid", 64'(router_out_valid), 64'd0);
    check("rst_ovf", 64'(tx_overflow), 64'd0);
    check("rst_avail", 64'(rx_available), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_mor", 64'(message_out_ready), 64'd1);

    // ---------------- TX vector table
    vecs[0]  = mk(1, 1, 0, 0, 32'h0,        0, 0, 0, 0, '0,                         1, 0);
    vecs[1]  = mk(0, 0, 0, 1, 32'h0,        0, 0, 0, 0, '0,                         1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 1, 0, '0,                         1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 32'h0,        0, 1, 1, 1, pk(1, 0, 32'hDEADBEEF),     0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 0, '0,                         1, 0);
    vecs[5]  = mk(0, 0, 0, 0, 32'h11,       1, 0, 0, 0, '0,                         1, 0);
    vecs[6]  = mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 1, pk(1, 0, 32'h11),           0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 32'h22,       1, 0, 0, 1, pk(1, 0, 32'h11),           0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 1, pk(1, 0, 32'h11),           0, 1);
    vecs[9]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 0, '0,                         1, 1);
    vecs[10] = mk(0, 0, 0, 0, 32'h11,       1, 0, 0, 0, '0,                         1, 1);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 1, pk(1, 0, 32'h11),           0, 1);
    vecs[12] = mk(0, 0, 0, 0, 32'h33,       1, 0, 0, 1, pk(1, 0, 32'h11),           0, 1);
    vecs[13] = mk(0, 0, 0, 0, 32'h0,        0, 1, 1, 1, pk(1, 0, 32'h33),           0, 1);
    vecs[14] = mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 0, '0,                         1, 1);
    vecs[15] = mk(0, 0, 0, 0, 32'h44,       1, 1, 0, 1, pk(1, 0, 32'h33),           0, 1);
    vecs[16] = mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 0, '0,                         1, 1);
    vecs[17] = mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 1, pk(1, 0, 32'h44),           0, 1);
    vecs[18] = mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 0, '0,                         1, 1);

    for (int i = 0; i < 19; i++) begin
      x_coord_in = vecs[i].x;   x_coord_in_valid = vecs[i].xv;
      y_coord_in = vecs[i].y;   y_coord_in_valid = vecs[i].yv;
      message_in = vecs[i].msg; message_in_valid = vecs[i].mv;
      packet_complete = vecs[i].pc;
      router_out_ready = vecs[i].ordy;
      tick();
      check($sformatf("vec%0d_valid", i), 64'(router_out_valid), 64'(vecs[i].e_valid));
      if (vecs[i].e_valid)
        check($sformatf("vec%0d_pkt", i), 64'(router_out_packet), 64'(vecs[i].e_pkt));
      check($sformatf("vec%0d_mor", i), 64'(message_out_ready), 64'(vecs[i].e_mor));
      check($sformatf("vec%0d_ovf", i), 64'(tx_overflow), 64'(vecs[i].e_ovf));
    end
    x_coord_in_valid = 0; y_coord_in_valid = 0; message_in_valid = 0;
    packet_complete = 0; router_out_ready = 0;

    // ---------------- RX fill / drain with destination check
    rxp[0] = pk(1, 1, 32'hA0);
    rxp[1] = pk(0, 1, 32'hA1);
    rxp[2] = pk(1, 0, 32'hA2);
    rxp[3] = pk(1, 1, 32'hA3);
    rxp[4] = pk(0, 0, 32'hA4);
    check("rx_ready_before_en", 64'(router_in_ready), 64'd0);
    rx_enable = 1'b1;
    tick();
    rx_enable = 1'b0;
    check("rx_ready_after_en", 64'(router_in_ready), 64'd1);
    router_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      router_in_packet = rxp[i];
      tick();
      if (i == 0) begin
        check("rx_first_avail", 64'(rx_available), 64'd1);
        check("rx_first_msg", 64'(rx_message), 64'hA0);
      end
    end
    check("rx_full_ready", 64'(router_in_ready), 64'd0);
    check("rx_head0_valid", 64'(rx_valid), 64'd1);
    router_in_packet = rxp[4];
    tick();
    tick();
    check("rx_full_hold_ready", 64'(router_in_ready), 64'd0);
    check("rx_full_hold_msg", 64'(rx_message), 64'hA0);
    rx_read = 1'b1;
    tick();
    rx_read = 1'b0;
    check("rx_pop_ready", 64'(router_in_ready), 64'd1);
    tick();
    check("rx_refill_ready", 64'(router_in_ready), 64'd0);
    router_in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic exp_v;
      exp_v = (k == 3);
      check($sformatf("rx_drain%0d_avail", k), 64'(rx_available), 64'd1);
      check($sformatf("rx_drain%0d_msg", k), 64'(rx_message), 64'(32'hA0 + k));
      check($sformatf("rx_drain%0d_valid", k), 64'(rx_valid), 64'(exp_v));
      rx_read = 1'b1;
      tick();
      rx_read = 1'b0;
    end
    check("rx_empty_avail", 64'(rx_available), 64'd0);
    check("rx_empty_ready", 64'(router_in_ready), 64'd1);
    rx_read = 1'b1;
    tick();
    rx_read = 1'b0;
    check("rx_empty_read_avail", 64'(rx_available), 64'd0);

    // ---------------- asynchronous reset mid-operation
    message_in = 32'h55; message_in_valid = 1'b1;
    tick();
    message_in_valid = 1'b0;
    packet_complete = 1'b1;
    tick();
    tick();
    packet_complete = 1'b0;
    router_in_valid = 1'b1;
    router_in_packet = rxp[0];
    tick();
    tick();
    router_in_valid = 1'b0;
    check("ar_pre_valid", 64'(router_out_valid), 64'd1);
    check("ar_pre_ovf", 64'(tx_overflow), 64'd1);
    check("ar_pre_avail", 64'(rx_available), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", 64'(router_out_valid), 64'd0);
    check("ar_avail", 64'(rx_available), 64'd0);
    check("ar_rin_ready", 64'(router_in_ready), 64'd0);
    check("ar_ovf", 64'(tx_overflow), 64'd0);
    check("ar_mor", 64'(message_out_ready), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("ar_post_mor", 64'(message_out_ready), 64'd1);
    check("ar_post_rin_ready", 64'(router_in_ready), 64'd0);

    // ---------------- random traffic against a queue-level model
    m_pend = 0; m_pkt = '0; m_xs = 0; m_ys = 0; m_ms = '0; m_ovf = 0; m_en = 0;
    m_q.delete();
    for (int c = 0; c < 400; c++) begin
      logic xfer, accept, do_push, do_pop;
      x_coord_in = 1'($urandom);       x_coord_in_valid = ($urandom_range(3, 0) == 0);
      y_coord_in = 1'($urandom);       y_coord_in_valid = ($urandom_range(3, 0) == 0);
      message_in = $urandom;           message_in_valid = ($urandom_range(2, 0) == 0);
      packet_complete  = ($urandom_range(3, 0) == 0);
      router_out_ready = ($urandom_range(2, 0) != 0);
      router_in_packet = {2'($urandom_range(3, 0)), 32'($urandom)};
      router_in_valid  = ($urandom_range(1, 0) == 0);
      rx_read          = ($urandom_range(2, 0) == 0);
      rx_enable        = (c > 60) && ($urandom_range(19, 0) == 0);

      xfer    = m_pend && router_out_ready;
      accept  = packet_complete && (!m_pend || router_out_ready);
      do_push = router_in_valid && m_en && (m_q.size() < DEPTH);
      do_pop  = rx_read && (m_q.size() > 0);
      if (accept) begin
        m_pend = 1;
        m_pkt  = {m_xs, m_ys, m_ms};
      end else if (xfer) begin
        m_pend = 0;
      end
      if (packet_complete && !accept) m_ovf = 1;
      if (x_coord_in_valid) m_xs = x_coord_in;
      if (y_coord_in_valid) m_ys = y_coord_in;
      if (message_in_valid) m_ms = message_in;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(router_in_packet);
      if (rx_enable) m_en = 1;

      tick();
      check($sformatf("r%0d_valid", c), 64'(router_out_valid), 64'(m_pend));
      if (m_pend) check($sformatf("r%0d_pkt", c), 64'(router_out_packet), 64'(m_pkt));
      check($sformatf("r%0d_mor", c), 64'(message_out_ready), 64'(!m_pend));
      check($sformatf("r%0d_ovf", c), 64'(tx_overflow), 64'(m_ovf));
      check($sformatf("r%0d_rin_ready", c), 64'(router_in_ready),
            64'(m_en && (m_q.size() < DEPTH)));
      check($sformatf("r%0d_avail", c), 64'(rx_available), 64'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        check($sformatf("r%0d_msg", c), 64'(rx_message), 64'(m_q[0][31:0]));
        check($sformatf("r%0d_rxvalid", c), 64'(rx_valid),
              64'((m_q[0][33] == 1'b1) && (m_q[0][32] == 1'b1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_packet_interface.md
# noc_packet_interface

Network interface between the processor node's memory-mapped I/O strobes and its Hoplite router port. On transmit, it gathers the processor's x/y destination and message writes into a packet and injects it into the router with a valid/ready handshake. On receive, it accepts ejected packets into a small show-ahead FIFO that the processor polls and pops through its input registers.

## Interface
Parameters:
- COORD_BITS, 1, width of each x/y coordinate
- MESSAGE_BITS, 32, payload width
- X_COORD, 0, this node's x coordinate
- Y_COORD, 0, this node's y coordinate
- RX_FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2
- PACKET_BITS, 2*COORD_BITS+MESSAGE_BITS, packet width; layout is {x_dest, y_dest, message}, with message in the LSBs

Ports:
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- x_coord_in  in  COORD_BITS  destination x from the processor
- x_coord_in_valid  in  1  one-cycle strobe; load x staging register
- y_coord_in  in  COORD_BITS  destination y from the processor
- y_coord_in_valid  in  1  one-cycle strobe; load y staging register
- message_in  in  MESSAGE_BITS  payload from the processor
- message_in_valid  in  1  one-cycle strobe; load message staging register
- packet_complete  in  1  one-cycle strobe; commit staging registers as a packet
- message_out_ready  out  1  TX slot free; polled by the processor
- tx_overflow  out  1  sticky; set when a commit is rejected
- router_out_packet  out  PACKET_BITS  packet to the router injection port
- router_out_valid  out  1  injection request
- router_out_ready  in  1  router accepts the injection this cycle
- router_in_packet  in  PACKET_BITS  ejected packet from the router
- router_in_valid  in  1  ejected packet present
- router_in_ready  out  1  interface can take an ejection; router deflects when this is low
- rx_enable  in  1  one-cycle strobe from the processor; sets the sticky receive-enable flag
- rx_message  out  MESSAGE_BITS  FIFO head payload (show-ahead)
- rx_available  out  1  FIFO not empty
- rx_valid  out  1  head present and its destination equals (X_COORD, Y_COORD)
- rx_read  in  1  one-cycle strobe; pop the FIFO head

## Operation
- **Reset:** all registers and outputs are cleared to 0, so message_out_ready=0 and router_in_ready=0 during reset.
  - One cycle after reset deasserts, message_out_ready rises to 1.
  - Reset mid-operation discards the pending TX packet and all FIFO contents.
- **TX staging:** each *_valid strobe overwrites its own staging register.
  - Staging is independent of the pending packet; staging registers may be written while a packet is pending.
  - Staging registers keep their value after a commit, so repeated sends to the same destination need only a message write.
- **TX commit:** packet_complete is accepted when no packet is pending, or when the pending packet transfers in the same cycle (back-to-back).
  - Accepted: the output register loads {x_stage, y_stage, msg_stage} and router_out_valid is set.
  - Rejected: the pending packet is unchanged and tx_overflow is set. tx_overflow clears only on reset.
  - Strobes for x, y or message in the same cycle as packet_complete are not part of that packet; the committed packet uses the pre-edge staging values.
- **TX handshake:** a transfer occurs when router_out_valid and router_out_ready are both high.
  - router_out_packet is held stable while valid is high and not transferred.
  - After a transfer, valid clears unless a commit is accepted in the same cycle.
  - message_out_ready is the registered inverse of the pending flag.
- **RX enable:** the rx_enable strobe sets a sticky enable flag; only reset clears it.
  - router_in_ready = enable AND NOT full, registered from the current state.
  - A push occurs when router_in_valid and router_in_ready are both high.
  - The FIFO stores the full packet; rx_valid compares the head's destination fields with the node coordinates.
- **RX FIFO:** read and write pointers are log2(RX_FIFO_DEPTH)+1 bits and wrap modulo 2·depth.
  - Full when the pointer MSBs differ and the rest are equal; empty when the pointers are equal.
  - rx_read on an empty FIFO is ignored.
  - Push and pop in the same cycle leave the count unchanged.
  - No push can occur while full, because ready is already low.

## Timing
- Commit at edge N: router_out_valid=1 and message_out_ready=0 from N+1.
  - Minimum hold of router_out_valid is 1 cycle.
- Transfer at edge T with no new commit: router_out_valid=0 and message_out_ready=1 from T+1.
- Push at edge M into an empty FIFO: rx_available and rx_message are valid from M+1.
- Pop at edge P: the next head, or empty, is visible from P+1.
- router_in_ready after the FIFO fills: low from the cycle after the filling push; high again the cycle after a pop.
- rx_enable at edge E: router_in_ready is high from E+1 if the FIFO is not full.

## Test plan
- **Basic send:** reset; write x=1, y=0, msg=0xDEADBEEF, then packet_complete with router_out_ready=1 -> router_out_packet={1,0,0xDEADBEEF} valid for exactly 1 cycle; message_out_ready returns to 1 one cycle later.
- **Backpressure and overflow:** router_out_ready=0; commit msg=0x11, then change the message staging register to 0x22 and commit again -> the packet stays 0x11 with valid held high and tx_overflow=1; raising ready transfers 0x11 only.
- **Back-to-back:** with a 0x11 packet pending, commit 0x33 in the same cycle that ready=1 -> 0x11 transfers, then 0x33 is valid on the next cycle with no gap.
- **RX fill/drain (depth 4):** rx_enable, then push 5 packets with router_in_valid held high -> 4 accepted, router_in_ready=0; after one rx_read the fifth is accepted; data emerges in FIFO order and rx_available=0 after 4 further reads.
- **Destination check:** at X_COORD=1, Y_COORD=1, push dest (1,1) then dest (0,1) -> rx_valid=1 for the first head, 0 for the second, rx_available=1 for both.
- **Async reset mid-transfer:** assert reset with a TX packet pending and 2 RX entries -> router_out_valid, rx_available, router_in_ready and tx_overflow are all 0 immediately, without waiting for a clock edge.
